// File: rtl/fibonacci_core.sv
// Fibonacci term generator driving user IO pads [IO_PADS-1:8].
// Optional macro FIB_WRAP_IRQ_EN enables the registered wrap_irq pulse.
module fibonacci_core #(
   parameter int CLOCK_WIDTH = 6,
   parameter int IO_PADS     = 38,
   parameter int VAL_WIDTH   = 30
) (
   input  logic                   wb_clk_i,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [CLOCK_WIDTH-1:0] clock_op,
   output logic [IO_PADS-1:0]     io_out,
   output logic [IO_PADS-1:0]     io_oeb,
   output logic                   step_o,
   output logic                   wrap_irq
);

   if (VAL_WIDTH != IO_PADS - 8) begin : g_width_check
      $error("fibonacci_core: VAL_WIDTH must equal IO_PADS-8");
   end

   typedef enum logic [1:0] {SEED, IDLE, RUN} state_t;

   state_t                 state, state_n;
   logic [VAL_WIDTH-1:0]   a, b;
   logic [VAL_WIDTH:0]     sum;
   logic [CLOCK_WIDTH-1:0] div_cnt, div_cnt_n;
   logic                   wrap_pending;
   logic                   do_step;

   assign sum    = {1'b0, a} + {1'b0, b};
   assign io_out = {a, 8'h00};
   assign io_oeb = {{VAL_WIDTH{1'b0}}, 8'hFF};

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state   <= SEED;
         div_cnt <= '0;
      end else begin
         state   <= state_n;
         div_cnt <= div_cnt_n;
      end
   end

   // Dropping enable takes priority over a tick due in the same cycle.
   always_comb begin
      state_n   = state;
      div_cnt_n = div_cnt;
      do_step   = 1'b0;
      case (state)
         SEED: begin
            div_cnt_n = '0;
            state_n   = enable ? RUN : IDLE;
         end
         IDLE: begin
            div_cnt_n = '0;
            if (enable) state_n = RUN;
         end
         RUN: begin
            if (!enable) begin
               state_n   = IDLE;
               div_cnt_n = '0;
            end else if (clock_op == '0) begin
               div_cnt_n = '0;
            end else if (div_cnt >= clock_op - CLOCK_WIDTH'(1)) begin
               div_cnt_n = '0;
               do_step   = 1'b1;
            end else begin
               div_cnt_n = div_cnt + CLOCK_WIDTH'(1);
            end
         end
         default: state_n = SEED;
      endcase
   end

   // Overflow shows b once more, then the following step reloads 0/1.
   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         a            <= '0;
         b            <= VAL_WIDTH'(1);
         wrap_pending <= 1'b0;
         step_o       <= 1'b0;
      end else begin
         step_o <= do_step;
         if (do_step) begin
            if (wrap_pending) begin
               a            <= '0;
               b            <= VAL_WIDTH'(1);
               wrap_pending <= 1'b0;
            end else if (sum[VAL_WIDTH]) begin
               a            <= b;
               wrap_pending <= 1'b1;
            end else begin
               a <= b;
               b <= sum[VAL_WIDTH-1:0];
            end
         end
      end
   end

`ifdef FIB_WRAP_IRQ_EN
   always_ff @(posedge wb_clk_i) begin
      if (reset) wrap_irq <= 1'b0;
      else       wrap_irq <= do_step & wrap_pending;
   end
`else
   assign wrap_irq = 1'b0;
`endif

endmodule

// File: tb/tb_fibonacci_core.sv
// Bench for fibonacci_core: term-index reference model plus scenario tasks.
module tb_fibonacci_core;
   logic        wb_clk_i = 1'b0;
   logic        reset    = 1'b1;
   logic        enable   = 1'b0;
   logic [5:0]  clock_op = '0;
   logic [37:0] io_out, io_oeb;
   logic        step_o, wrap_irq;

   localparam logic [37:0] OEB_EXP = 38'h00_0000_00FF;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position in the 45-term sequence plus elapsed-cycle count.
   longint fibv[45];
   int     m_idx = 0;
   int     m_cnt = 0;
   bit     m_seed = 1'b1, m_run = 1'b0, m_step = 1'b0, m_wrap = 1'b0;

   fibonacci_core #(.CLOCK_WIDTH(6), .IO_PADS(38), .VAL_WIDTH(30)) dut (
      .wb_clk_i (wb_clk_i),
      .reset    (reset),
      .enable   (enable),
      .clock_op (clock_op),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .step_o   (step_o),
      .wrap_irq (wrap_irq)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   function automatic logic [37:0] exp_io();
      logic [29:0] v;
      v = 30'(fibv[m_idx]);
      return {v, 8'h00};
   endfunction

   function automatic logic exp_wrap();
`ifdef FIB_WRAP_IRQ_EN
      return m_wrap;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (reset) begin
         m_idx = 0; m_cnt = 0; m_seed = 1'b1; m_run = 1'b0;
      end else if (m_seed) begin
         m_seed = 1'b0; m_run = enable; m_cnt = 0;
      end else if (!m_run) begin
         m_run = enable; m_cnt = 0;
      end else if (!enable) begin
         m_run = 1'b0; m_cnt = 0;
      end else if (clock_op == 0) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt >= int'(clock_op)) begin
            m_cnt  = 0;
            m_step = 1'b1;
            m_wrap = (m_idx == 44);
            m_idx  = (m_idx == 44) ? 0 : m_idx + 1;
         end
      end
      #1;
   endtask

   task automatic restart(input logic [5:0] op);
      reset = 1'b1; tick();
      reset = 1'b0; enable = 1'b1; clock_op = op;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; clock_op = 6'd1;
      tick(); tick();
      n_tests++; if (io_out !== 38'd0) begin n_fail++; $display("FAIL reset_io_out: got %h expected 0", io_out); end
      n_tests++; if (io_oeb !== OEB_EXP) begin n_fail++; $display("FAIL reset_io_oeb: got %h expected %h", io_oeb, OEB_EXP); end
      n_tests++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL reset_step_o: got %b expected 0", step_o); end
      n_tests++; if (wrap_irq !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_irq: got %b expected 0", wrap_irq); end
   endtask

   task automatic test_sequence();
      int exp_a[7] = '{0, 1, 1, 2, 3, 5, 8};
      bit exp_s[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_tests++;
         if (io_out[37:8] !== 30'(exp_a[i])) begin
            n_fail++; $display("FAIL seq_a[%0d]: got %0d expected %0d", i, io_out[37:8], exp_a[i]);
         end
         n_tests++;
         if (step_o !== exp_s[i]) begin
            n_fail++; $display("FAIL seq_step[%0d]: got %b expected %b", i, step_o, exp_s[i]);
         end
      end
   endtask

   task automatic test_period();
      int last = -1;
      restart(6'd4);
      for (int i = 0; i < 40; i++) begin
         tick();
         n_tests++;
         if (io_out !== exp_io() || step_o !== m_step) begin
            n_fail++; $display("FAIL period_out[%0d]: got %h/%b expected %h/%b", i, io_out, step_o, exp_io(), m_step);
         end
         n_tests++;
         if (io_out[7:0] !== 8'h00 || io_oeb !== OEB_EXP) begin
            n_fail++; $display("FAIL period_pads[%0d]: got %h/%h expected 00/%h", i, io_out[7:0], io_oeb, OEB_EXP);
         end
         if (step_o === 1'b1) begin
            if (last >= 0) begin
               n_tests++;
               if (i - last != 4) begin n_fail++; $display("FAIL period_gap: got %0d expected 4", i - last); end
            end
            last = i;
         end
      end
   endtask

   task automatic test_wrap();
      int pulses = 0;
      restart(6'd1);
      for (int i = 0; i < 55; i++) begin
         tick();
         n_tests++;
         if (io_out !== exp_io() || wrap_irq !== exp_wrap()) begin
            n_fail++; $display("FAIL wrap_out[%0d]: got %h/%b expected %h/%b", i, io_out, wrap_irq, exp_io(), exp_wrap());
         end
         if (m_idx == 43 && m_step) begin
            n_tests++;
            if (io_out[37:8] !== 30'd433494437) begin n_fail++; $display("FAIL wrap_f43: got %0d expected 433494437", io_out[37:8]); end
         end
         if (m_idx == 44 && m_step) begin
            n_tests++;
            if (io_out[37:8] !== 30'd701408733) begin n_fail++; $display("FAIL wrap_f44: got %0d expected 701408733", io_out[37:8]); end
         end
         if (wrap_irq === 1'b1) pulses++;
      end
      n_tests++;
`ifdef FIB_WRAP_IRQ_EN
      if (pulses != 1) begin n_fail++; $display("FAIL wrap_irq_count: got %0d expected 1", pulses); end
`else
      if (pulses != 0) begin n_fail++; $display("FAIL wrap_irq_count: got %0d expected 0", pulses); end
`endif
   endtask

   task automatic test_pause();
      int budget = 30;
      restart(6'd1);
      while (m_idx != 7 && budget > 0) begin tick(); budget--; end
      n_tests++;
      if (io_out[37:8] !== 30'd13) begin n_fail++; $display("FAIL pause_reach13: got %0d expected 13", io_out[37:8]); end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (io_out[37:8] !== 30'd13 || step_o !== 1'b0) begin
            n_fail++; $display("FAIL pause_hold[%0d]: got %0d/%b expected 13/0", i, io_out[37:8], step_o);
         end
      end
      enable = 1'b1; clock_op = 6'd2;
      tick(); tick();
      n_tests++;
      if (io_out[37:8] !== 30'd13) begin n_fail++; $display("FAIL pause_resume_hold: got %0d expected 13", io_out[37:8]); end
      tick();
      n_tests++;
      if (io_out[37:8] !== 30'd21 || step_o !== 1'b1) begin
         n_fail++; $display("FAIL pause_resume_21: got %0d/%b expected 21/1", io_out[37:8], step_o);
      end
   endtask

   task automatic test_clock_change();
      int budget = 20;
      logic [37:0] frozen;
      restart(6'd8);
      while (!(m_run && m_cnt == 5) && budget > 0) begin tick(); budget--; end
      n_tests++;
      if (budget == 0) begin n_fail++; $display("FAIL clkchg_budget: got timeout expected div_cnt=5"); end
      clock_op = 6'd1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (step_o !== 1'b1 || io_out !== exp_io()) begin
            n_fail++; $display("FAIL clkchg_step[%0d]: got %h/%b expected %h/1", i, io_out, step_o, exp_io());
         end
      end
      frozen = exp_io();
      clock_op = 6'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (step_o !== 1'b0 || io_out !== frozen) begin
            n_fail++; $display("FAIL clkchg_freeze[%0d]: got %h/%b expected %h/0", i, io_out, step_o, frozen);
         end
      end
   endtask

   task automatic test_reset_mid();
      int exp_a[4] = '{0, 1, 1, 2};
      for (int pass = 0; pass < 2; pass++) begin
         int target = (pass == 0) ? 11 : 44;
         int budget = 60;
         restart(6'd1);
         while (m_idx != target && budget > 0) begin tick(); budget--; end
         n_tests++;
         if (io_out !== exp_io()) begin n_fail++; $display("FAIL rstmid_pre[%0d]: got %h expected %h", pass, io_out, exp_io()); end
         if (pass == 0) begin
            n_tests++;
            if (io_out[37:8] !== 30'd89) begin n_fail++; $display("FAIL rstmid_89: got %0d expected 89", io_out[37:8]); end
         end
         reset = 1'b1; tick(); reset = 1'b0;
         n_tests++;
         if (io_out !== 38'd0 || step_o !== 1'b0 || wrap_irq !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_clear[%0d]: got %h/%b/%b expected 0/0/0", pass, io_out, step_o, wrap_irq);
         end
         for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (io_out[37:8] !== 30'(exp_a[i]) || wrap_irq !== 1'b0) begin
               n_fail++; $display("FAIL rstmid_restart[%0d][%0d]: got %0d/%b expected %0d/0", pass, i, io_out[37:8], wrap_irq, exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      restart(6'd1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 8) clock_op = 6'($urandom_range(6));
         enable = ($urandom_range(99) < 90);
         reset  = ($urandom_range(199) == 0);
         tick();
         n_tests++;
         if (io_out !== exp_io() || io_oeb !== OEB_EXP) begin
            n_fail++; $display("FAIL rand_io[%0d]: got %h/%h expected %h/%h", i, io_out, io_oeb, exp_io(), OEB_EXP);
         end
         n_tests++;
         if (step_o !== m_step || wrap_irq !== exp_wrap()) begin
            n_fail++; $display("FAIL rand_pulse[%0d]: got %b/%b expected %b/%b", i, step_o, wrap_irq, m_step, exp_wrap());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fibv[0] = 0;
      fibv[1] = 1;
      for (int i = 2; i < 45; i++) fibv[i] = fibv[i-1] + fibv[i-2];
      test_reset();
      test_sequence();
      test_period();
      test_wrap();
      test_pause();
      test_clock_change();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
